chd_op_scheduler: RTL

//  Shares one count/hold/add datapath (3-bit adder + 4-bit counter, 2-bit mode select) between two requesters.

---
 rtl/chd_op_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/chd_op_scheduler.sv
// rtl/chd_op_scheduler.sv - two-requester round-robin scheduler for a shared count/hold/add datapath
module chd_op_scheduler #(
    parameter int LEN_W = 4,
    parameter int DW    = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [3:0]         req_op_i,
    input  logic [2*DW-1:0]    req_a_i,
    input  logic [2*DW-1:0]    req_b_i,
    input  logic [2*LEN_W-1:0] req_len_i,
    output logic [1:0]         dp_sel_o,
    output logic [DW-1:0]      dp_a_o,
    output logic [DW-1:0]      dp_b_o,
    input  logic [DW:0]        dp_dout_i,
    output logic               rsp_valid_o,
    output logic               rsp_id_o,
    output logic [DW:0]        rsp_data_o,
    output logic               rsp_err_o,
    output logic               busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_HOLD  = 2'b01;
    localparam logic [1:0] OP_ILLEG = 2'b11;

    logic [1:0]       state_q, state_d;
    logic             rr_q, rr_d;
    logic [1:0]       sel_q, sel_d;
    logic [DW-1:0]    a_q, a_d;
    logic [DW-1:0]    b_q, b_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             id_q, id_d;
    logic             rsp_id_q, rsp_id_d;
    logic [DW:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             grant_vld;
    logic             grant_id;
    logic [1:0]       g_op;
    logic [DW-1:0]    g_a;
    logic [DW-1:0]    g_b;
    logic [LEN_W-1:0] g_len;
    logic [LEN_W-1:0] g_len_eff;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = rr_q;
        if (state_q == S_IDLE) begin
            if (req_valid_i[rr_q]) begin
                grant_vld = 1'b1;
                grant_id  = rr_q;
            end else if (req_valid_i[~rr_q]) begin
                grant_vld = 1'b1;
                grant_id  = ~rr_q;
            end
        end
    end

    assign req_ready_o = grant_vld ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    assign g_op      = grant_id ? req_op_i[3:2] : req_op_i[1:0];
    assign g_a       = grant_id ? req_a_i[2*DW-1:DW] : req_a_i[DW-1:0];
    assign g_b       = grant_id ? req_b_i[2*DW-1:DW] : req_b_i[DW-1:0];
    assign g_len     = grant_id ? req_len_i[2*LEN_W-1:LEN_W] : req_len_i[LEN_W-1:0];
    // A zero dwell still needs one cycle to sample the datapath
    assign g_len_eff = (g_len == '0) ? LEN_W'(1) : g_len;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        sel_d      = sel_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        id_d       = id_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    rr_d = ~grant_id;
                    id_d = grant_id;
                    if (g_op == OP_ILLEG) begin
                        state_d    = S_RESP;
                        rsp_id_d   = grant_id;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                        sel_d   = g_op;
                        a_d     = g_a;
                        b_d     = g_b;
                        rem_d   = (g_op == OP_ADD) ? LEN_W'(1) : g_len_eff;
                    end
                end
            end
            S_EXEC: begin
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d    = S_RESP;
                    rsp_data_d = dp_dout_i;
                    rsp_id_d   = id_q;
                    rsp_err_d  = 1'b0;
                    sel_d      = OP_HOLD;
                    a_d        = '0;
                    b_d        = '0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = OP_HOLD;
                a_d     = '0;
                b_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            rr_q       <= 1'b0;
            sel_q      <= OP_HOLD;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            id_q       <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            sel_q      <= sel_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            id_q       <= id_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign dp_sel_o    = sel_q;
    assign dp_a_o      = a_q;
    assign dp_b_o      = b_q;
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
